apb_master_ctrl: RTL

Single-outstanding APB master bridge: accepts read/write commands on a valid/ready command port, runs the APB SETUP/ACCESS sequence on the bus, and returns read data and error status on a valid/ready response port. It sits directly upstream of `apb_slave` (the student-record register file) and is the only driver of its `paddr/pwdata/psel/penable/pwrite` inputs. A wait-cycle timeout guards against a slave that never raises `pready`.

---
 rtl/apb_master_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB master bridging a cmd/rsp valid-ready port to APB with wait timeout
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [CW-1:0] wcnt;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state       <= IDLE;
      wcnt        <= '0;
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          paddr  <= cmd_addr;
          pwdata <= cmd_wdata;
          pwrite <= cmd_write;
          psel   <= 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          wcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: if (pready) begin
          rsp_rdata   <= pwrite ? '0 : prdata;
          rsp_err     <= pslverr;
          rsp_timeout <= 1'b0;
          psel        <= 1'b0;
          penable     <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end else begin
          wcnt <= (wcnt == '1) ? wcnt : wcnt + 1'b1;
          if (TIMEOUT != 0 && wcnt == TLAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
